// File: rtl/pulse_stretch_if.sv
// pulse_stretch_if: control, event and status bundle for the pulse stretcher.
// master drives en/retrig/len/clr/in and observes out/busy/drop; slave is the stretcher.
interface pulse_stretch_if #(
    parameter int DW = 1,
    parameter int CW = 8
);
    logic          en;
    logic          retrig;
    logic          clr;
    logic [CW-1:0] len;
    logic [DW-1:0] in;
    logic [DW-1:0] out;
    logic          busy;
    logic [DW-1:0] drop;
    modport master (output en, retrig, clr, len, in, input out, busy, drop);
    modport slave  (input en, retrig, clr, len, in, output out, busy, drop);
endinterface

// File: rtl/pulse_stretch.sv
// pulse_stretch: turns single-cycle pulses into registered windows of len cycles per channel.
// clk/nreset (async, active-low); ps carries en, retrig, len, clr, in -> out, busy, drop.
module pulse_stretch #(
    parameter int DW = 1,
    parameter int CW = 8
) (
    input logic           clk,
    input logic           nreset,
    pulse_stretch_if.slave ps
);
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    state_t        state_q [DW];
    state_t        state_d [DW];
    logic [CW-1:0] cnt_q [DW];
    logic [CW-1:0] cnt_d [DW];
    logic [DW-1:0] drop_q, drop_d, out_w;
    logic [CW-1:0] lm1;
    // Reload value L-1, with len==0 behaving as a one-cycle window.
    assign lm1 = (ps.len == '0) ? '0 : ps.len - CW'(1);
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int k = 0; k < DW; k++) begin
                state_q[k] <= IDLE;
                cnt_q[k]   <= '0;
            end
            drop_q <= '0;
        end else begin
            for (int k = 0; k < DW; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            drop_q <= drop_d;
        end
    end
    always_comb begin
        drop_d = drop_q & ~{DW{ps.clr}};
        for (int k = 0; k < DW; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            if (state_q[k] == IDLE) begin
                if (ps.in[k] && ps.en) begin
                    state_d[k] = ACTIVE;
                    cnt_d[k]   = lm1;
                end
            end else if (ps.in[k] && ps.en && (ps.retrig || cnt_q[k] == '0)) begin
                // Retrigger, or a pulse in the final cycle merging into a new window.
                cnt_d[k] = lm1;
            end else if (cnt_q[k] == '0) begin
                state_d[k] = IDLE;
            end else begin
                cnt_d[k] = cnt_q[k] - CW'(1);
                // Reaching here with an accepted pulse means retrig=0: discard it.
                if (ps.in[k] && ps.en) drop_d[k] = 1'b1;
            end
        end
    end
    always_comb begin
        out_w = '0;
        for (int k = 0; k < DW; k++) out_w[k] = (state_q[k] == ACTIVE);
    end
    assign ps.out  = out_w;
    assign ps.busy = |out_w;
    assign ps.drop = drop_q;
endmodule

// File: tb/tb_pulse_stretch.sv
// tb_pulse_stretch: vector table plus scoreboard and hand-written async-reset sequence.
module tb_pulse_stretch;
    typedef struct {
        logic       en;
        logic       retrig;
        logic       clr;
        logic [7:0] len;
        logic [3:0] in;
        logic [3:0] eo;
        logic [3:0] ed;
    } vec_t;
    typedef struct {
        logic [3:0] eo;
        logic [3:0] ed;
        int         idx;
    } exp_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    int checks = 0;
    int failures = 0;
    vec_t vecs[$];
    exp_t sb[$];

    pulse_stretch_if #(.DW(4), .CW(8)) ps();
    pulse_stretch #(.DW(4), .CW(8)) dut (.clk(clk), .nreset(nreset), .ps(ps));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", nm, idx, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic en, input logic rt, input logic cl, input logic [7:0] ln,
                                input logic [3:0] i, input logic [3:0] eo, input logic [3:0] ed);
        vec_t v;
        v.en = en; v.retrig = rt; v.clr = cl; v.len = ln; v.in = i; v.eo = eo; v.ed = ed;
        return v;
    endfunction

    task automatic add(input logic en, input logic rt, input logic cl, input logic [7:0] ln,
                       input logic [3:0] i, input logic [3:0] eo, input logic [3:0] ed);
        vecs.push_back(mk(en, rt, cl, ln, i, eo, ed));
    endtask

    // Drive one cycle of stimulus, queue the outputs expected after the edge, then compare.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        ps.en = v.en; ps.retrig = v.retrig; ps.clr = v.clr; ps.len = v.len; ps.in = v.in;
        sb.push_back('{eo: v.eo, ed: v.ed, idx: idx});
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", idx, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("out", e.idx, {28'd0, ps.out}, {28'd0, e.eo});
            chk("busy", e.idx, {31'd0, ps.busy}, {31'd0, |e.eo});
            chk("drop", e.idx, {28'd0, ps.drop}, {28'd0, e.ed});
        end
    endtask

    initial begin
        ps.en = 1'b0; ps.retrig = 1'b0; ps.clr = 1'b0; ps.len = 8'd0; ps.in = 4'd0;

        // isolated pulse, len=5; len changed mid-window must not matter
        add(1,0,0,5,4'b0001,4'b0001,4'b0000);
        add(1,0,0,200,4'b0000,4'b0001,4'b0000);
        add(1,0,0,5,4'b0000,4'b0001,4'b0000);
        add(1,0,0,5,4'b0000,4'b0001,4'b0000);
        add(1,0,0,5,4'b0000,4'b0001,4'b0000);
        add(1,0,0,5,4'b0000,4'b0000,4'b0000);
        // len=0 -> one cycle
        add(1,0,0,0,4'b0010,4'b0010,4'b0000);
        add(1,0,0,0,4'b0000,4'b0000,4'b0000);
        add(1,0,0,0,4'b0000,4'b0000,4'b0000);
        // retrig=1, len=4, pulses at 0 and 2 -> high 6 cycles
        add(1,1,0,4,4'b0001,4'b0001,4'b0000);
        add(1,1,0,4,4'b0000,4'b0001,4'b0000);
        add(1,1,0,4,4'b0001,4'b0001,4'b0000);
        add(1,1,0,4,4'b0000,4'b0001,4'b0000);
        add(1,1,0,4,4'b0000,4'b0001,4'b0000);
        add(1,1,0,4,4'b0000,4'b0001,4'b0000);
        add(1,1,0,4,4'b0000,4'b0000,4'b0000);
        // retrig=0, same stimulus -> high 4 cycles, drop from cycle 3, clr at cycle 8
        add(1,0,0,4,4'b0001,4'b0001,4'b0000);
        add(1,0,0,4,4'b0000,4'b0001,4'b0000);
        add(1,0,0,4,4'b0001,4'b0001,4'b0001);
        add(1,0,0,4,4'b0000,4'b0001,4'b0001);
        add(1,0,0,4,4'b0000,4'b0000,4'b0001);
        add(1,0,0,4,4'b0000,4'b0000,4'b0001);
        add(1,0,0,4,4'b0000,4'b0000,4'b0001);
        add(1,0,0,4,4'b0000,4'b0000,4'b0001);
        add(1,0,1,4,4'b0000,4'b0000,4'b0000);
        // back-to-back: len=3, pulses at 0 and 3, retrig=0 -> 6 merged cycles, no drop
        add(1,0,0,3,4'b0001,4'b0001,4'b0000);
        add(1,0,0,3,4'b0000,4'b0001,4'b0000);
        add(1,0,0,3,4'b0000,4'b0001,4'b0000);
        add(1,0,0,3,4'b0001,4'b0001,4'b0000);
        add(1,0,0,3,4'b0000,4'b0001,4'b0000);
        add(1,0,0,3,4'b0000,4'b0001,4'b0000);
        add(1,0,0,3,4'b0000,4'b0000,4'b0000);
        // en=0 pulse ignored
        add(0,0,0,3,4'b0001,4'b0000,4'b0000);
        add(0,0,0,3,4'b0000,4'b0000,4'b0000);
        // en dropped mid-window: window completes, pulse with en=0 is not a drop
        add(1,0,0,4,4'b0100,4'b0100,4'b0000);
        add(0,0,0,4,4'b0000,4'b0100,4'b0000);
        add(0,0,0,4,4'b0100,4'b0100,4'b0000);
        add(0,0,0,4,4'b0000,4'b0100,4'b0000);
        add(0,0,0,4,4'b0000,4'b0000,4'b0000);
        // retrig=1 held input: high until L=2 cycles after it falls
        add(1,1,0,2,4'b0010,4'b0010,4'b0000);
        add(1,1,0,2,4'b0010,4'b0010,4'b0000);
        add(1,1,0,2,4'b0010,4'b0010,4'b0000);
        add(1,1,0,2,4'b0000,4'b0010,4'b0000);
        add(1,1,0,2,4'b0000,4'b0000,4'b0000);
        // channels 0 and 3 together; discard on ch3 with clr in the same cycle keeps drop
        add(1,0,0,3,4'b1001,4'b1001,4'b0000);
        add(1,0,0,3,4'b1000,4'b1001,4'b1000);
        add(1,0,1,3,4'b1000,4'b1001,4'b1000);
        add(1,0,0,3,4'b0000,4'b0000,4'b1000);
        add(1,0,1,3,4'b0000,4'b0000,4'b0000);

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out", -1, {28'd0, ps.out}, 32'd0);
        chk("rst_busy", -1, {31'd0, ps.busy}, 32'd0);
        chk("rst_drop", -1, {28'd0, ps.drop}, 32'd0);
        #3 nreset = 1'b1;

        for (int k = 0; k < vecs.size(); k++) apply(vecs[k], k);

        // async reset at window cycle 3, len=6 on ch1
        apply(mk(1,0,0,6,4'b0010,4'b0010,4'b0000), 1000);
        apply(mk(1,0,0,6,4'b0000,4'b0010,4'b0000), 1001);
        apply(mk(1,0,0,6,4'b0000,4'b0010,4'b0000), 1002);
        #2 nreset = 1'b0;
        #1;
        chk("async_out", 1003, {28'd0, ps.out}, 32'd0);
        chk("async_busy", 1003, {31'd0, ps.busy}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        for (int k = 0; k < 7; k++)
            apply(mk(1,0,0,6,(k == 0) ? 4'b0010 : 4'b0000, (k < 6) ? 4'b0010 : 4'b0000, 4'b0000), 1010 + k);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_stretch.md
# pulse_stretch

Multi-channel pulse stretcher: converts single-cycle event pulses into registered level windows of programmable length. It is the complement of the edge-to-pulse converter in the common library. Fast-domain strobes become wide, glitch-free levels that slow logic, LEDs or interrupt controllers can sample. Each of the DW channels runs independently with its own down-counter, retrigger handling and sticky drop flag.

## Interface
- DW, 1, number of independent channels
- CW, 8, counter width; maximum stretch is 2^CW-1 cycles

- clk  input  1  clock
- nreset  input  1  reset nreset, asynchronous, active-low
- en  input  1  global enable; when 0, new pulses are ignored (no drop flagged)
- retrig  input  1  1 = a pulse during an active window restarts the count; 0 = it is dropped
- len  input  CW  stretch length in cycles; 0 is treated as 1
- clr  input  1  clears all drop flags
- in  input  DW  event pulses, synchronous to clk
- out  output  DW  stretched level, registered
- busy  output  1  OR-reduction of out
- drop  output  DW  sticky flag: a pulse was discarded in non-retrigger mode

## Operation
- Each channel has state IDLE (out=0) or ACTIVE (out=1), plus a counter cnt[CW-1:0].
- L = (len==0) ? 1 : len, sampled only at trigger time; changing len mid-window does not affect the running window.
- IDLE, in[i]&en: go to ACTIVE, cnt<=L-1.
- IDLE, otherwise: stay IDLE.
- ACTIVE, in[i]&en&retrig: cnt<=L-1 and stay ACTIVE (restart).
- ACTIVE, cnt==0, in[i]&en (either retrig value): cnt<=L-1 and stay ACTIVE, so back-to-back windows merge with no low cycle. This is not a drop.
- ACTIVE, cnt==0, no accepted pulse: go to IDLE.
- ACTIVE, cnt!=0, in[i]&en&!retrig: pulse discarded, drop[i]<=1, cnt decrements normally.
- ACTIVE, cnt!=0, otherwise: cnt<=cnt-1.
- en=0 suppresses new triggers only. Active windows run to completion, and drop is not set.
- drop[i]: set by a discard event, cleared by clr. If set and clr occur in the same cycle, set wins.
- Counter arithmetic is unsigned CW bits. cnt never decrements below 0, so there is no wrap.
- busy = |out. It is combinational from registered out and adds no extra latency.

## Timing
- Reset values: out=0, busy=0, drop=0, cnt=0, all channels IDLE. Reset is asynchronous and takes effect mid-window: out falls immediately.
- Latency: out[i] rises on the first clk edge after in[i] is sampled high, i.e. 1 cycle.
- Isolated pulse: out high for exactly L consecutive cycles.
- Retriggered pulse at window cycle k (1-based): total high time = k + L cycles.
- Pulse arriving in the final high cycle: window extends by L cycles, with no gap.
- A multi-cycle-high input is treated as a pulse every cycle. With retrig=1, out stays high until L cycles after in falls. With retrig=0, the window is L cycles, then restarts if in is still high, and drop is set for each discarded cycle.
- Channels are fully independent. Simultaneous pulses on different channels produce identical timing.
- drop rises 1 cycle after the discard event. clr takes effect on the next edge.

## Test plan
- Reset and isolated pulse:
  - Reset asserted -> out=0, busy=0, drop=0.
  - len=5, one-cycle in[0] at cycle 10 -> out[0]=1 on cycles 11–15, 0 at 16; busy matches.
- len=0: single pulse -> out high for exactly 1 cycle.
- Retrigger:
  - retrig=1, len=4, pulses at cycles 0 and 2 -> out high on cycles 1–6 (6 cycles), drop=0.
  - retrig=0, same stimulus -> out high on cycles 1–4, drop[0]=1 from cycle 3.
  - clr at cycle 8 -> drop=0 at cycle 9.
- Back-to-back and enable:
  - len=3, pulses at cycles 0 and 3 (final cycle) with retrig=0 -> out high on cycles 1–6 continuously, drop=0.
  - en=0 during a pulse -> no window and no drop.
  - en dropped mid-window -> window completes its full length.
- Reset and multi-channel:
  - DW=4, len=6: nreset asserted at window cycle 3 -> out=0 asynchronously; after release, a new pulse gives a full 6-cycle window.
  - Simultaneous pulses on channels 0 and 3, plus clr and a discard event in the same cycle -> drop remains set.
